// File: rtl/balls_pkg.sv
// Shared constants for the key-input path and the ADALINE predictor core.
//   CLK_HZ            : system clock frequency
//   DEBOUNCE_DEFAULT  : default debounce interval, 10 ms at CLK_HZ
//   EV_K1 / EV_K2     : event encodings, same as the predictor core's xin values
package balls_pkg;

    localparam int   CLK_HZ           = 50_000_000;
    localparam int   DEBOUNCE_DEFAULT = CLK_HZ / 100;
    localparam logic EV_K1            = 1'b1;
    localparam logic EV_K2            = 1'b0;

endpackage

// File: rtl/key_debounce.sv
// One push-button conditioner: 2-flop synchroniser, debouncer and press pulse.
//   CLOCK_50 : clock
//   reset    : synchronous, active-high
//   raw      : raw button, asynchronous, active-low
//   level    : debounced level, active-high (pressed = 1)
//   press    : one-cycle pulse on each debounced press
module key_debounce
    import balls_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = 19
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    logic [1:0]       sync_reg;
    logic             st_reg, st_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             level_reg;
    logic             press_reg;

    always_comb begin
        st_next  = st_reg;
        cnt_next = cnt_reg;
        if (sync_reg[1] == st_reg) begin
            cnt_next = '0;
        end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            st_next  = sync_reg[1];
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync_reg  <= 2'b11;
            st_reg    <= 1'b1;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            press_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], raw};
            st_reg    <= st_next;
            cnt_reg   <= cnt_next;
            level_reg <= ~st_reg;
            // level_reg still holds ~st from the previous cycle, so this
            // fires exactly once, in step with level rising.
            press_reg <= ~st_reg & ~level_reg;
        end
    end

    assign level = level_reg;
    assign press = press_reg;

endmodule

// File: rtl/key_event_conditioner.sv
// Conditions buttons k1/k2 into single-bit press events behind a one-entry
// valid/ready buffer for the predictor core.
//   CLOCK_50 : clock          reset    : synchronous, active-high
//   k1, k2   : raw buttons, asynchronous, active-low
//   ev_valid : event pending  ev_bit   : 1 = k1 press, 0 = k2 press
//   ev_ready : consumer takes the pending event this cycle
//   k1_down, k2_down : debounced levels, active-high
//   drop_cnt : saturating count of discarded presses
module key_event_conditioner
    import balls_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = 19,
    parameter int DROP_W          = 8
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              k1,
    input  logic              k2,
    output logic              ev_valid,
    output logic              ev_bit,
    input  logic              ev_ready,
    output logic              k1_down,
    output logic              k2_down,
    output logic [DROP_W-1:0] drop_cnt
);

    // Index 0 is k1, index 1 is k2.
    logic [1:0] raw_key;
    logic [1:0] level_key;
    logic [1:0] press_key;

    assign raw_key = {k2, k1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_debounce (
                .CLOCK_50 (CLOCK_50),
                .reset    (reset),
                .raw      (raw_key[gi]),
                .level    (level_key[gi]),
                .press    (press_key[gi])
            );
        end
    endgenerate

    logic              ev_valid_reg, ev_valid_next;
    logic              ev_bit_reg, ev_bit_next;
    logic [DROP_W-1:0] drop_cnt_reg, drop_cnt_next;
    logic              accept;
    logic              slot_free;
    logic [1:0]        drop_inc;
    logic [DROP_W:0]   drop_sum;

    always_comb begin
        accept        = ev_valid_reg & ev_ready;
        slot_free     = ~ev_valid_reg | accept;
        ev_valid_next = ev_valid_reg;
        ev_bit_next   = ev_bit_reg;
        drop_inc      = 2'd0;

        if (slot_free) begin
            // k1 wins a tie; a simultaneous k2 press is discarded.
            if (press_key[0]) begin
                ev_valid_next = 1'b1;
                ev_bit_next   = EV_K1;
                drop_inc      = {1'b0, press_key[1]};
            end else if (press_key[1]) begin
                ev_valid_next = 1'b1;
                ev_bit_next   = EV_K2;
            end else if (accept) begin
                ev_valid_next = 1'b0;
            end
        end else begin
            drop_inc = {1'b0, press_key[0]} + {1'b0, press_key[1]};
        end

        drop_sum = {1'b0, drop_cnt_reg} + (DROP_W + 1)'(drop_inc);
        if (drop_sum[DROP_W]) begin
            drop_cnt_next = '1;
        end else begin
            drop_cnt_next = drop_sum[DROP_W-1:0];
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            ev_valid_reg <= 1'b0;
            ev_bit_reg   <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            ev_valid_reg <= ev_valid_next;
            ev_bit_reg   <= ev_bit_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    assign ev_valid = ev_valid_reg;
    assign ev_bit   = ev_bit_reg;
    assign k1_down  = level_key[0];
    assign k2_down  = level_key[1];
    assign drop_cnt = drop_cnt_reg;

endmodule
